// File: rtl/ir_sensor_acq.sv
// -----------------------------------------------------------------------------
// ir_sensor_acq
//
// Purpose:
//   Periodic IR wall-sensor acquisition front end for the heading-fusion math.
//   Every PERIOD_CLKS clocks it:
//     1. enables the IR emitters,
//     2. waits for the receivers to settle,
//     3. requests a left conversion, then a right conversion, from the shared A2D,
//     4. publishes the scaled readings, the open-wall flags (with hysteresis)
//        and a saturated derivative of the left-right difference.
//   If the A2D does not answer within TIMEOUT_CLKS, the acquisition is
//   abandoned and IR_err pulses.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   cnv_cmplt  in   1   A2D conversion done, 1-clk pulse, res valid same clk
//   res        in  12   A2D result, unsigned
//   IR_en      out  1   IR emitter enable
//   strt_cnv   out  1   1-clk conversion request to the A2D
//   chnnl      out  3   A2D channel, stable from strt_cnv until cnv_cmplt
//   lft_IR     out 12   signed left reading
//   rght_IR    out 12   signed right reading
//   lft_opn    out  1   left side open
//   rght_opn   out  1   right side open
//   IR_Dtrm    out  9   signed derivative term
//   IR_vld     out  1   1-clk pulse when new outputs are valid
//   IR_err     out  1   1-clk pulse on A2D timeout
// -----------------------------------------------------------------------------
module ir_sensor_acq #(
    parameter int unsigned        PERIOD_CLKS  = 4096,
    parameter int unsigned        SETTLE_CLKS  = 256,
    parameter int unsigned        TIMEOUT_CLKS = 1024,
    parameter logic [2:0]         LFT_CHNL     = 3'd0,
    parameter logic [2:0]         RGHT_CHNL    = 3'd4,
    parameter logic signed [11:0] OPN_THRESH   = 12'sh200,
    parameter logic signed [11:0] OPN_HYST     = 12'sh020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        IR_en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] lft_IR,
    output logic [11:0] rght_IR,
    output logic        lft_opn,
    output logic        rght_opn,
    output logic [8:0]  IR_Dtrm,
    output logic        IR_vld,
    output logic        IR_err
);

    localparam int PER_W = (PERIOD_CLKS  > 1) ? $clog2(PERIOD_CLKS)      : 1;
    localparam int SET_W = $clog2(SETTLE_CLKS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    // Open-flag thresholds widened to 13 bits so THRESH+HYST cannot overflow.
    localparam logic signed [12:0] OPN_SET = {OPN_THRESH[11], OPN_THRESH};
    localparam logic signed [12:0] OPN_CLR = OPN_SET + {OPN_HYST[11], OPN_HYST};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ_L,
        S_WAIT_L,
        S_REQ_R,
        S_WAIT_R,
        S_UPDATE
    } state_t;

    state_t             r_state;
    logic [PER_W-1:0]   r_per_cnt;
    logic [SET_W-1:0]   r_set_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [11:0]        r_lft_cap;
    logic [11:0]        r_rght_cap;
    logic signed [12:0] r_prev_diff;
    logic               r_first;

    logic               r_ir_en;
    logic               r_strt_cnv;
    logic [2:0]         r_chnnl;
    logic [11:0]        r_lft_ir;
    logic [11:0]        r_rght_ir;
    logic               r_lft_opn;
    logic               r_rght_opn;
    logic [8:0]         r_ir_dtrm;
    logic               r_ir_vld;
    logic               r_ir_err;

    logic               w_tick;
    logic signed [12:0] w_lft_x;
    logic signed [12:0] w_rght_x;
    logic signed [12:0] w_diff;
    logic signed [13:0] w_dd;
    logic [8:0]         w_dd_sat;
    logic               w_lft_opn_nxt;
    logic               w_rght_opn_nxt;
    logic               w_unused;

    // The readings are halved, so the A2D LSB is intentionally dropped.
    assign w_unused = res[0];

    assign w_tick = (r_per_cnt == PER_W'(PERIOD_CLKS - 1));

    // Captured readings always have bit 11 clear, so sign extension is safe.
    assign w_lft_x  = {r_lft_cap[11],  r_lft_cap};
    assign w_rght_x = {r_rght_cap[11], r_rght_cap};

    always_comb begin
        w_diff = w_lft_x - w_rght_x;
        w_dd   = {w_diff[12], w_diff} - {r_prev_diff[12], r_prev_diff};
        if (w_dd > 14'sd255) begin
            w_dd_sat = 9'h0FF;
        end else if (w_dd < -14'sd256) begin
            w_dd_sat = 9'h100;
        end else begin
            w_dd_sat = w_dd[8:0];
        end
    end

    // Hysteresis: set below OPN_SET, clear only above OPN_CLR, hold on equality.
    always_comb begin
        w_lft_opn_nxt  = r_lft_opn  ? !(w_lft_x  > OPN_CLR) : (w_lft_x  < OPN_SET);
        w_rght_opn_nxt = r_rght_opn ? !(w_rght_x > OPN_CLR) : (w_rght_x < OPN_SET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_per_cnt   <= '0;
            r_set_cnt   <= '0;
            r_to_cnt    <= '0;
            r_lft_cap   <= '0;
            r_rght_cap  <= '0;
            r_prev_diff <= '0;
            r_first     <= 1'b1;
            r_ir_en     <= 1'b0;
            r_strt_cnv  <= 1'b0;
            r_chnnl     <= '0;
            r_lft_ir    <= '0;
            r_rght_ir   <= '0;
            r_lft_opn   <= 1'b1;
            r_rght_opn  <= 1'b1;
            r_ir_dtrm   <= '0;
            r_ir_vld    <= 1'b0;
            r_ir_err    <= 1'b0;
        end else begin
            // Pulse outputs default low each clock.
            r_strt_cnv <= 1'b0;
            r_ir_vld   <= 1'b0;
            r_ir_err   <= 1'b0;

            // Free-running period counter; ticks outside IDLE are simply lost.
            if (w_tick) begin
                r_per_cnt <= '0;
            end else begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state   <= S_SETTLE;
                        r_ir_en   <= 1'b1;
                        r_set_cnt <= '0;
                    end
                end

                S_SETTLE: begin
                    if (r_set_cnt == SET_W'(SETTLE_CLKS - 1)) begin
                        r_state <= S_REQ_L;
                    end else begin
                        r_set_cnt <= r_set_cnt + 1'b1;
                    end
                end

                S_REQ_L: begin
                    r_strt_cnv <= 1'b1;
                    r_chnnl    <= LFT_CHNL;
                    r_to_cnt   <= '0;
                    r_state    <= S_WAIT_L;
                end

                S_WAIT_L: begin
                    // A completion beats a timeout landing on the same clock.
                    if (cnv_cmplt) begin
                        r_lft_cap <= {1'b0, res[11:1]};
                        r_state   <= S_REQ_R;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        r_state  <= S_IDLE;
                        r_ir_en  <= 1'b0;
                        r_ir_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_REQ_R: begin
                    r_strt_cnv <= 1'b1;
                    r_chnnl    <= RGHT_CHNL;
                    r_to_cnt   <= '0;
                    r_state    <= S_WAIT_R;
                end

                S_WAIT_R: begin
                    if (cnv_cmplt) begin
                        r_rght_cap <= {1'b0, res[11:1]};
                        r_state    <= S_UPDATE;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        r_state  <= S_IDLE;
                        r_ir_en  <= 1'b0;
                        r_ir_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_UPDATE: begin
                    r_ir_en     <= 1'b0;
                    r_lft_ir    <= r_lft_cap;
                    r_rght_ir   <= r_rght_cap;
                    r_lft_opn   <= w_lft_opn_nxt;
                    r_rght_opn  <= w_rght_opn_nxt;
                    // No valid history on the first sample, so report no change.
                    r_ir_dtrm   <= r_first ? 9'h000 : w_dd_sat;
                    r_prev_diff <= w_diff;
                    r_first     <= 1'b0;
                    r_ir_vld    <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ir_en <= 1'b0;
                end
            endcase
        end
    end

    assign IR_en    = r_ir_en;
    assign strt_cnv = r_strt_cnv;
    assign chnnl    = r_chnnl;
    assign lft_IR   = r_lft_ir;
    assign rght_IR  = r_rght_ir;
    assign lft_opn  = r_lft_opn;
    assign rght_opn = r_rght_opn;
    assign IR_Dtrm  = r_ir_dtrm;
    assign IR_vld   = r_ir_vld;
    assign IR_err   = r_ir_err;

endmodule

// File: tb/tb_ir_sensor_acq.sv
// -----------------------------------------------------------------------------
// tb_ir_sensor_acq
//
// Directed bench for ir_sensor_acq. A small A2D model answers each strt_cnv
// 20 clocks later with res_l or res_r depending on the requested channel,
// unless a2d_on is cleared. Edge numbers are counted from reset release:
// edge 1 is the first rising edge with rst low.
// -----------------------------------------------------------------------------
module tb_ir_sensor_acq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        IR_en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] lft_IR;
    logic [11:0] rght_IR;
    logic        lft_opn;
    logic        rght_opn;
    logic [8:0]  IR_Dtrm;
    logic        IR_vld;
    logic        IR_err;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          t0    = 0;
    int          vld_cnt = 0;
    int          err_cnt = 0;
    int          en_gap  = 0;
    bit          a2d_on  = 1'b0;
    logic [11:0] res_l   = 12'h000;
    logic [11:0] res_r   = 12'h000;

    // Reset image of {IR_en,strt_cnv,chnnl,lft_IR,rght_IR,lft_opn,rght_opn,IR_Dtrm,IR_vld,IR_err}
    localparam logic [41:0] RST_IMG = {1'b0, 1'b0, 3'd0, 12'h000, 12'h000,
                                       1'b1, 1'b1, 9'h000, 1'b0, 1'b0};

    ir_sensor_acq dut (
        .clk       (clk),
        .rst       (rst),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .IR_en     (IR_en),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .lft_IR    (lft_IR),
        .rght_IR   (rght_IR),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .IR_Dtrm   (IR_Dtrm),
        .IR_vld    (IR_vld),
        .IR_err    (IR_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        if (IR_vld) vld_cnt = vld_cnt + 1;
        if (IR_err) err_cnt = err_cnt + 1;
    end

    // A2D model: 20-clock latency from strt_cnv to cnv_cmplt.
    initial begin
        logic [2:0] ch;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        forever begin
            @(negedge clk);
            if (strt_cnv && a2d_on && !rst) begin
                ch = chnnl;
                repeat (19) @(posedge clk);
                @(negedge clk);
                res       = (ch == 3'd0) ? res_l : res_r;
                cnv_cmplt = 1'b1;
                @(negedge clk);
                cnv_cmplt = 1'b0;
            end
        end
    end

    // which: 0 = IR_en high, 1 = strt_cnv, 2 = IR_vld, 3 = IR_err
    task automatic wait_for(input int which, input int limit, output bit ok, output int edge_n);
        bit hit;
        ok = 1'b0;
        edge_n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = IR_en;
                1:       hit = strt_cnv;
                2:       hit = IR_vld;
                default: hit = IR_err;
            endcase
            if (which == 2 && !hit && !IR_en) en_gap = en_gap + 1;
            if (hit) begin
                ok = 1'b1;
                edge_n = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({IR_en, strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld, IR_err} !== RST_IMG) begin
            bad++;
            $display("FAIL reset_values: got %h want %h",
                     {IR_en, strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld, IR_err}, RST_IMG);
        end
    endtask

    task automatic test_first_acq();
        bit ok;
        int e;
        res_l  = 12'hC00;
        res_r  = 12'h800;
        a2d_on = 1'b1;
        rst    = 1'b0;
        t0     = cyc;
        $display("first acquisition: res_l=%h res_r=%h", res_l, res_r);

        wait_for(0, 5000, ok, e);
        total++;
        if (!ok || e !== 4096) begin
            bad++; $display("FAIL settle_entry_edge: got ok=%0d edge=%0d want edge=4096", ok, e);
        end

        wait_for(1, 1000, ok, e);
        total++;
        if (!ok || e !== 4353 || chnnl !== 3'd0) begin
            bad++; $display("FAIL strt_left: got ok=%0d edge=%0d chnnl=%0d want edge=4353 chnnl=0", ok, e, chnnl);
        end

        wait_for(1, 100, ok, e);
        total++;
        if (!ok || e !== 4374 || chnnl !== 3'd4) begin
            bad++; $display("FAIL strt_right: got ok=%0d edge=%0d chnnl=%0d want edge=4374 chnnl=4", ok, e, chnnl);
        end

        en_gap = 0;
        wait_for(2, 100, ok, e);
        total++;
        if (!ok || e !== 4395 || en_gap !== 0 || IR_en !== 1'b0) begin
            bad++; $display("FAIL vld_timing: got ok=%0d edge=%0d en_gap=%0d IR_en=%b want edge=4395 en_gap=0 IR_en=0",
                            ok, e, en_gap, IR_en);
        end
        total++;
        if ({lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm} !== {12'h600, 12'h400, 1'b0, 1'b0, 9'h000}) begin
            bad++; $display("FAIL first_sample: got lft=%h rght=%h lo=%b ro=%b dtrm=%h want 600 400 0 0 000",
                            lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm);
        end
        @(negedge clk);
        total++;
        if (IR_vld !== 1'b0) begin
            bad++; $display("FAIL vld_pulse_width: got IR_vld=%b one clk later want 0", IR_vld);
        end
    endtask

    task automatic acquire(input logic [11:0] rl, input logic [11:0] rr, output bit ok);
        int e;
        res_l  = rl;
        res_r  = rr;
        a2d_on = 1'b1;
        wait_for(2, 6000, ok, e);
        $display("acquisition: res_l=%h res_r=%h -> lft=%h rght=%h lo=%b ro=%b dtrm=%h",
                 rl, rr, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm);
    endtask

    task automatic test_derivative();
        bit ok;
        acquire(12'hC80, 12'h800, ok);
        total++;
        if (!ok || lft_IR !== 12'h640 || IR_Dtrm !== 9'd64) begin
            bad++; $display("FAIL deriv_64: got ok=%0d lft=%h dtrm=%h want lft=640 dtrm=040", ok, lft_IR, IR_Dtrm);
        end
        acquire(12'hFFE, 12'h000, ok);
        total++;
        if (!ok || lft_IR !== 12'h7FF || rght_IR !== 12'h000 || IR_Dtrm !== 9'h0FF || rght_opn !== 1'b1) begin
            bad++; $display("FAIL deriv_sat_pos: got ok=%0d lft=%h rght=%h dtrm=%h ro=%b want 7ff 000 0ff 1",
                            ok, lft_IR, rght_IR, IR_Dtrm, rght_opn);
        end
    endtask

    task automatic test_hysteresis();
        bit ok;
        acquire(12'h3FE, 12'h800, ok);
        total++;
        if (!ok || lft_IR !== 12'h1FF || lft_opn !== 1'b1 || rght_opn !== 1'b0 || IR_Dtrm !== 9'h100) begin
            bad++; $display("FAIL hyst_set: got ok=%0d lft=%h lo=%b ro=%b dtrm=%h want 1ff 1 0 100",
                            ok, lft_IR, lft_opn, rght_opn, IR_Dtrm);
        end
        acquire(12'h420, 12'h800, ok);
        total++;
        if (!ok || lft_IR !== 12'h210 || lft_opn !== 1'b1 || IR_Dtrm !== 9'd17) begin
            bad++; $display("FAIL hyst_hold: got ok=%0d lft=%h lo=%b dtrm=%h want 210 1 011",
                            ok, lft_IR, lft_opn, IR_Dtrm);
        end
        acquire(12'h442, 12'h800, ok);
        total++;
        if (!ok || lft_IR !== 12'h221 || lft_opn !== 1'b0 || IR_Dtrm !== 9'd17) begin
            bad++; $display("FAIL hyst_clear: got ok=%0d lft=%h lo=%b dtrm=%h want 221 0 011",
                            ok, lft_IR, lft_opn, IR_Dtrm);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int s;
        int e;
        int v0;
        a2d_on = 1'b0;
        v0 = vld_cnt;
        wait_for(1, 6000, ok, s);
        wait_for(3, 1100, ok, e);
        $display("timeout: strt edge=%0d err edge=%0d", s, e);
        total++;
        if (!ok || (e - s) !== 1024 || IR_en !== 1'b0) begin
            bad++; $display("FAIL timeout_timing: got ok=%0d delay=%0d IR_en=%b want delay=1024 IR_en=0", ok, e - s, IR_en);
        end
        total++;
        if (vld_cnt !== v0 || {lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm} !== {12'h221, 12'h400, 1'b0, 1'b0, 9'd17}) begin
            bad++; $display("FAIL timeout_hold: got vlds=%0d lft=%h rght=%h lo=%b ro=%b dtrm=%h want vlds=%0d 221 400 0 0 011",
                            vld_cnt, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, v0);
        end
        @(negedge clk);
        total++;
        if (IR_err !== 1'b0) begin
            bad++; $display("FAIL err_pulse_width: got IR_err=%b one clk later want 0", IR_err);
        end
    endtask

    task automatic test_recover();
        bit ok;
        // diff 512 against held prev_diff -479 -> +991 saturates.
        acquire(12'hC00, 12'h800, ok);
        total++;
        if (!ok || lft_IR !== 12'h600 || rght_IR !== 12'h400 || IR_Dtrm !== 9'h0FF) begin
            bad++; $display("FAIL recover: got ok=%0d lft=%h rght=%h dtrm=%h want 600 400 0ff", ok, lft_IR, rght_IR, IR_Dtrm);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int e;
        int v0;
        a2d_on = 1'b0;
        wait_for(1, 6000, ok, e);
        repeat (3) @(negedge clk);
        res = 12'hC00; cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        wait_for(1, 100, ok, e);
        total++;
        if (!ok || chnnl !== 3'd4) begin
            bad++; $display("FAIL mid_reach_wait_r: got ok=%0d chnnl=%0d want chnnl=4", ok, chnnl);
        end
        repeat (5) @(negedge clk);
        v0  = vld_cnt;
        rst = 1'b1;
        res = 12'h800; cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        @(negedge clk);
        $display("reset asserted during WAIT_R");
        total++;
        if ({IR_en, strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld, IR_err} !== RST_IMG || vld_cnt !== v0) begin
            bad++;
            $display("FAIL mid_reset_values: got %h vlds=%0d want %h vlds=%0d",
                     {IR_en, strt_cnv, chnnl, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld, IR_err}, vld_cnt, RST_IMG, v0);
        end
        res_l  = 12'hC80;
        res_r  = 12'h800;
        rst    = 1'b0;
        t0     = cyc;
        a2d_on = 1'b1;
        wait_for(0, 5000, ok, e);
        total++;
        if (!ok || e !== 4096 || vld_cnt !== v0) begin
            bad++; $display("FAIL post_reset_start: got ok=%0d edge=%0d vlds=%0d want edge=4096 vlds=%0d", ok, e, vld_cnt, v0);
        end
        wait_for(2, 1000, ok, e);
        total++;
        if (!ok || lft_IR !== 12'h640 || rght_IR !== 12'h400 || IR_Dtrm !== 9'h000) begin
            bad++; $display("FAIL post_reset_first: got ok=%0d lft=%h rght=%h dtrm=%h want 640 400 000",
                            ok, lft_IR, rght_IR, IR_Dtrm);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_first_acq();
        test_derivative();
        test_hysteresis();
        test_timeout();
        test_recover();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
